async_fifo_wr_arbiter: RTL

Round-robin write-port arbiter that shares the single write port of the `ASYNC_FIFO` between `NUM_REQ` producers in the write clock domain. Each producer presents one word at a time on a req/ack handshake. The arbiter grants one producer at a time for a burst of up to `MAX_BURST` words and stalls on `wFull`. It drives `wData`/`winc` directly into the FIFO's write side and keeps a running count of words written.

---
 rtl/async_fifo_wr_arbiter_if.sv | 27 ++
 rtl/async_fifo_wr_arbiter.sv | 96 +++++++++
 2 files changed

// File: rtl/async_fifo_wr_arbiter_if.sv
// rtl/async_fifo_wr_arbiter_if.sv - producer/FIFO-side signal bundle for the write-port arbiter
interface async_fifo_wr_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4
);
  localparam int OW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic                          wFull;
  logic [NUM_REQ-1:0]            ack;
  logic [DATA_WIDTH-1:0]         wData;
  logic                          winc;
  logic [OW-1:0]                 owner;
  logic                          busy;
  logic [15:0]                   word_cnt;

  modport master (
    input  req, req_data, wFull,
    output ack, wData, winc, owner, busy, word_cnt
  );

  modport slave (
    output req, req_data, wFull,
    input  ack, wData, winc, owner, busy, word_cnt
  );
endinterface

// File: rtl/async_fifo_wr_arbiter.sv
// rtl/async_fifo_wr_arbiter.sv - round-robin burst arbiter sharing one FIFO write port
module async_fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                   wclk,
  input  logic                   wrst,
  async_fifo_wr_arbiter_if.master bus
);
  localparam int OW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST) + 1;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [OW-1:0]   ptr_q, ptr_d;
  logic [BW-1:0]   burst_q, burst_d;
  logic [15:0]     word_cnt_q, word_cnt_d;
  logic [OW-1:0]   pick;
  logic [OW-1:0]   owner_inc;
  logic            found;
  logic            accept;
  logic            last_word;
  int              idx;

  // First requester at or after ptr, wrapping modulo NUM_REQ.
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr_q) + i) % NUM_REQ;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        pick  = idx[OW-1:0];
      end
    end
  end

  assign owner_inc = (int'(owner_q) == NUM_REQ - 1) ? '0 : owner_q + 1'b1;
  assign accept    = (state_q == GRANT) && bus.req[owner_q] && !bus.wFull;
  assign last_word = (burst_q == BW'(MAX_BURST - 1));

  assign bus.winc     = accept;
  assign bus.ack      = accept ? (NUM_REQ'(1) << owner_q) : '0;
  assign bus.wData    = accept ? bus.req_data[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign bus.owner    = owner_q;
  assign bus.busy     = (state_q == GRANT);
  assign bus.word_cnt = word_cnt_q;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    burst_d    = burst_q;
    word_cnt_d = word_cnt_q + {15'd0, accept};
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          owner_d = pick;
          burst_d = '0;
        end
      end
      GRANT: begin
        if (accept) begin
          burst_d = burst_q + 1'b1;
        end
        // A stalled last word does not release; a dropped request always does.
        if ((accept && last_word) || !bus.req[owner_q]) begin
          state_d = IDLE;
          ptr_d   = owner_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      ptr_q      <= '0;
      burst_q    <= '0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      burst_q    <= burst_d;
      word_cnt_q <= word_cnt_d;
    end
  end
endmodule
